dot_accumulator: RTL and testbench
==================================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, giving the unsigned product (input term) width.
REQ-002 The block SHALL have parameter TERMS, default 4 (legal range 1..1024), giving the number of terms per dot product.
REQ-003 The block SHALL have parameter SUM_WIDTH, default IN_WIDTH+clog2(TERMS) (=10), giving the result width; values below that are illegal.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: abandon the partial group.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data holds a term.
REQ-008 The block SHALL have port in_data, input, IN_WIDTH bits: unsigned product term.
REQ-009 The block SHALL have port in_ready, output, 1 bit: term accepted when in_valid && in_ready.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_sum holds a completed dot product.
REQ-011 The block SHALL have port out_sum, output, SUM_WIDTH bits: zero-extended unsigned sum of TERMS terms.
REQ-012 The block SHALL have port out_ready, input, 1 bit: sink takes the result when out_valid && out_ready.

Function
REQ-013 The block SHALL implement FSM states IDLE (no partial group), ACCUM (1..TERMS-1 terms held) and HOLD (result pending, no partial group).
REQ-014 The block SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-015 The block SHALL load the accumulator with zero-extended in_data on the first accepted term of a group.
REQ-016 The block SHALL add each subsequent accepted term to the accumulator at full SUM_WIDTH, with no wrap or saturation.
REQ-017 The block SHALL hold a term counter 0..TERMS-1 that increments per accepted term and returns to 0 after the TERMS-th term.
REQ-018 The block SHALL register out_sum = accumulator + in_data and set out_valid on the cycle after the TERMS-th term is accepted (latency 1 cycle).
REQ-019 The block SHALL keep out_sum and out_valid stable while out_valid && !out_ready.
REQ-020 The block SHALL clear out_valid the cycle after the handshake, unless a new group completes in that same cycle, in which case out_valid stays high with the new sum (zero-bubble).
REQ-021 With TERMS=1, every accepted term SHALL produce one result, and ACCUM SHALL never be entered.
REQ-022 Flush SHALL zero the counter and accumulator and move ACCUM->IDLE; a pending result (HOLD/out_valid) SHALL be unaffected.
REQ-023 A flush asserted in the same cycle as in_valid SHALL take priority, and no term SHALL be accepted that cycle.
REQ-024 The transitions SHALL be: IDLE->ACCUM on accept (TERMS>1); ACCUM->HOLD on the TERMS-th accept; HOLD->IDLE on handshake without a completing group; HOLD stays HOLD otherwise.
REQ-025 in_data SHALL be ignored whenever no acceptance occurs.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, counter 0, accumulator 0, out_sum 0, out_valid 0, without waiting for a clock edge.
REQ-027 Reset mid-group or with a pending result SHALL discard both; the first accepted term after release SHALL start a new group.
REQ-028 With Reset_n low, in_ready SHALL read 0.
REQ-029 Release of Reset_n SHALL take effect on the next Clock rising edge.

Structure
REQ-030 A shared package SHALL hold the clog2 constant function, the FSM state typedef (IDLE/ACCUM/HOLD) and the SUM_WIDTH derivation.
REQ-031 The block SHALL have no sub-module; the counter, adder and output register SHALL sit in one module, with the adder inferred at SUM_WIDTH.

Verification
REQ-032 Defaults, out_ready=1, terms 255,255,255,255 on consecutive cycles -> out_valid one cycle after the 4th accept, out_sum=1020.
REQ-033 Terms 17,99,178,78 then 222,0,1,3 back-to-back with out_ready=1 -> out_sum=372 then 226, no idle cycle between groups.
REQ-034 Out_ready=0 after result 40 (10,10,10,10) -> out_sum held at 40; in_ready=0; next terms stall until out_ready=1.
REQ-035 Terms 69,69, flush, then 1,2,3,4 -> out_sum=10 (69s discarded); flush with in_valid high -> term not accepted.
REQ-036 Reset_n pulsed low asynchronously after 2 terms and with a held result -> out_valid=0 and out_sum=0 immediately; next 4 terms 5,5,5,5 -> out_sum=20.
REQ-037 TERMS=1, terms 7,9 with out_ready=1 -> out_sum=7 then 9 on consecutive cycles.

Source files
------------

// File: rtl/dot_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator: state encoding and
// the width derivations used by the top module's parameters.
package dot_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Smallest result width that can hold TERMS full-scale terms without wrapping.
    function automatic int sumWidth(input int inWidth, input int terms);
        return inWidth + clog2(terms);
    endfunction

    function automatic int countWidth(input int terms);
        return (terms > 1) ? clog2(terms) : 1;
    endfunction

endpackage

// File: rtl/dot_accumulator.sv
// Accumulates groups of TERMS unsigned product terms and presents each
// completed dot product on a valid/ready output with a one-deep result register.
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int TERMS     = 4,
    parameter int SUM_WIDTH = sumWidth(IN_WIDTH, TERMS)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [SUM_WIDTH-1:0] out_sum,
    input  logic                 out_ready
);

    localparam int              CNT_W      = countWidth(TERMS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TERMS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [SUM_WIDTH-1:0] accum_q, accum_d;
    logic [SUM_WIDTH-1:0] outSum_q, outSum_d;
    logic                 outValid_q, outValid_d;

    logic                 accept;
    logic                 lastTerm;
    logic                 handshake;
    logic [SUM_WIDTH-1:0] termExt;
    logic [SUM_WIDTH-1:0] sumNext;

    // Reset_n gates ready so nothing is taken while the block is held in reset.
    assign in_ready  = Reset_n && !flush && (!outValid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign lastTerm  = accept && (count_q == LAST_COUNT);
    assign handshake = outValid_q && out_ready;
    assign termExt   = SUM_WIDTH'(in_data);
    assign sumNext   = ((count_q == '0) ? '0 : accum_q) + termExt;

    assign out_valid = outValid_q;
    assign out_sum   = outSum_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            accum_q    <= '0;
            outSum_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            accum_q    <= accum_d;
            outSum_q   <= outSum_d;
            outValid_q <= outValid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        accum_d    = accum_q;
        outSum_d   = outSum_q;
        outValid_d = outValid_q;

        if (handshake) begin
            outValid_d = 1'b0;
        end

        // A completing group overrides the handshake clear, giving back-to-back results.
        if (flush) begin
            count_d = '0;
            accum_d = '0;
        end else if (accept) begin
            if (lastTerm) begin
                count_d    = '0;
                accum_d    = '0;
                outSum_d   = sumNext;
                outValid_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
                accum_d = sumNext;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = lastTerm ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (lastTerm) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (lastTerm) begin
                    state_d = HOLD;
                end else if (handshake) begin
                    state_d = accept ? ACCUM : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed and random checks of dot_accumulator against a queue-based model
// of the group/handshake rules, plus a TERMS=1 instance.
module tb_dot_accumulator;

    localparam int TERMS = 4;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_sum;
    logic       out_ready;

    logic       t1Flush;
    logic       t1Valid;
    logic [7:0] t1Data;
    logic       t1Ready;
    logic       t1OutValid;
    logic [7:0] t1OutSum;
    logic       t1OutReady;

    int total = 0;
    int bad   = 0;

    int         partial[$];
    logic       expValid;
    logic [9:0] expSum;

    always #5 Clock = ~Clock;

    dot_accumulator dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready)
    );

    dot_accumulator #(.IN_WIDTH(8), .TERMS(1)) dutSingle (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .flush     (t1Flush),
        .in_valid  (t1Valid),
        .in_data   (t1Data),
        .in_ready  (t1Ready),
        .out_valid (t1OutValid),
        .out_sum   (t1OutSum),
        .out_ready (t1OutReady)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic modelReady();
        return Reset_n && !flush && (!expValid || out_ready);
    endfunction

    task automatic checkOutput();
        checkValue("in_ready", {31'd0, in_ready}, {31'd0, modelReady()});
        checkValue("out_valid", {31'd0, out_valid}, {31'd0, expValid});
        checkValue("out_sum", {22'd0, out_sum}, {22'd0, expSum});
    endtask

    // Model of one rising edge: collect accepted terms, sum a full group.
    task automatic modelClock();
        logic acc;
        logic hs;
        int   s;
        if (!Reset_n) begin
            partial.delete();
            expValid = 1'b0;
            expSum   = '0;
            return;
        end
        acc = in_valid && modelReady();
        hs  = expValid && out_ready;
        if (hs) expValid = 1'b0;
        if (flush) begin
            partial.delete();
        end else if (acc) begin
            partial.push_back(int'(in_data));
            if (partial.size() == TERMS) begin
                s = 0;
                foreach (partial[i]) s += partial[i];
                expSum   = 10'(s);
                expValid = 1'b1;
                partial.delete();
            end
        end
    endtask

    task automatic applyStimulus(input logic f, input logic v, input logic [7:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        checkOutput();
        @(posedge Clock);
        modelClock();
        @(negedge Clock);
        #1;
    endtask

    task automatic assertReset();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        Reset_n = 1'b0;
        #1;
        checkValue("rst_valid", {31'd0, out_valid}, 32'd0);
        checkValue("rst_sum", {22'd0, out_sum}, 32'd0);
        checkValue("rst_ready", {31'd0, in_ready}, 32'd0);
        partial.delete();
        expValid = 1'b0;
        expSum   = '0;
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        t1Flush    = 1'b0;
        t1Valid    = 1'b0;
        t1Data     = '0;
        t1OutReady = 1'b1;
        expValid   = 1'b0;
        expSum     = '0;

        #2;
        checkValue("init_valid", {31'd0, out_valid}, 32'd0);
        checkValue("init_sum", {22'd0, out_sum}, 32'd0);
        checkValue("init_ready", {31'd0, in_ready}, 32'd0);
        checkValue("init_t1_valid", {31'd0, t1OutValid}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        #1;
        checkOutput();

        // TERMS=1: each term is its own result
        checkValue("t1_ready", {31'd0, t1Ready}, 32'd1);
        t1Data  = 8'd7;
        t1Valid = 1'b1;
        @(negedge Clock);
        #1;
        checkValue("t1_valid_a", {31'd0, t1OutValid}, 32'd1);
        checkValue("t1_sum_a", {24'd0, t1OutSum}, 32'd7);
        t1Data = 8'd9;
        @(negedge Clock);
        #1;
        checkValue("t1_valid_b", {31'd0, t1OutValid}, 32'd1);
        checkValue("t1_sum_b", {24'd0, t1OutSum}, 32'd9);
        t1Valid = 1'b0;
        @(negedge Clock);
        #1;
        checkValue("t1_valid_c", {31'd0, t1OutValid}, 32'd0);

        // Full-scale terms
        repeat (4) applyStimulus(1'b0, 1'b1, 8'd255, 1'b1);
        checkValue("max_valid", {31'd0, out_valid}, 32'd1);
        checkValue("max_sum", {22'd0, out_sum}, 32'd1020);

        // Back-to-back groups
        applyStimulus(1'b0, 1'b1, 8'd17, 1'b1);
        checkValue("b2b_clear", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd99, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd178, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd78, 1'b1);
        checkValue("b2b_sum_a", {22'd0, out_sum}, 32'd372);
        applyStimulus(1'b0, 1'b1, 8'd222, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
        checkValue("b2b_valid_b", {31'd0, out_valid}, 32'd1);
        checkValue("b2b_sum_b", {22'd0, out_sum}, 32'd226);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

        // Backpressure holds the result and stalls input
        repeat (4) applyStimulus(1'b0, 1'b1, 8'd10, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd50, 1'b0);
        checkValue("hold_sum", {22'd0, out_sum}, 32'd40);
        checkValue("hold_valid", {31'd0, out_valid}, 32'd1);
        checkValue("hold_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd60, 1'b0);
        checkValue("hold_sum_2", {22'd0, out_sum}, 32'd40);
        repeat (4) applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkValue("stall_sum", {22'd0, out_sum}, 32'd20);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

        // Flush with a coincident term, then a plain flush
        applyStimulus(1'b0, 1'b1, 8'd69, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd69, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'd99, 1'b1);
        checkValue("flush_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
        checkValue("flush_sum_a", {22'd0, out_sum}, 32'd10);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd69, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
        checkValue("flush_sum_b", {22'd0, out_sum}, 32'd10);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

        // Asynchronous reset mid-group and with a held result
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd6, 1'b1);
        assertReset();
        repeat (3) applyStimulus(1'b0, 1'b1, 8'd9, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkValue("pre_rst_sum", {22'd0, out_sum}, 32'd36);
        assertReset();
        repeat (4) applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkValue("post_rst_sum", {22'd0, out_sum}, 32'd20);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                assertReset();
            end else begin
                applyStimulus(($urandom_range(0, 15) == 0),
                              ($urandom_range(0, 3) != 0),
                              8'($urandom),
                              ($urandom_range(0, 3) != 0));
            end
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
